// File: rtl/tpu_timer_sched.sv
// tpu_timer_sched: round-robin owner of the single TPU interval timer.
// Grants one requester at a time, loads its compare value, runs the
// timer until TMR_INT (DONE) or CANCEL of the owner (CNCL_ACK).
// Ports: SYS_CLK/RSTTPU_N clock and async active-low reset;
//   REQ/REQ_VALUE/CANCEL per-requester inputs; GNT/DONE/CNCL_ACK
//   one-hot pulses; BUSY/CUR_ID/TIME status; TMR_RST/TMR_INTMSK/
//   TMR_INT_VALUE drive the timer, TMR_INT is its interrupt.
module tpu_timer_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 16
) (
    input  logic             SYS_CLK,
    input  logic             RSTTPU_N,
    input  logic [NREQ-1:0]  REQ,
    input  logic [NREQ*CW-1:0] REQ_VALUE,
    input  logic [NREQ-1:0]  CANCEL,
    output logic [NREQ-1:0]  GNT,
    output logic [NREQ-1:0]  DONE,
    output logic [NREQ-1:0]  CNCL_ACK,
    output logic             BUSY,
    output logic [2:0]       CUR_ID,
    output logic [7:0]       TIME,
    output logic             TMR_RST,
    output logic             TMR_INTMSK,
    output logic [CW-1:0]    TMR_INT_VALUE,
    input  logic             TMR_INT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] cncl_q, cncl_d;
    logic            busy_q, busy_d;
    logic [2:0]      cur_id_q, cur_id_d;
    logic [2:0]      rr_q, rr_d;
    logic [7:0]      time_q, time_d;
    logic            tmr_rst_q, tmr_rst_d;
    logic            tmr_msk_q, tmr_msk_d;
    logic [CW-1:0]   val_q, val_d;

    logic [2:0]      sel;
    logic [3:0]      idx;
    logic [CW-1:0]   sel_val;
    logic [2:0]      rr_next;
    logic            cncl_hit;

    // Scan offsets from high to low so the requester closest to the
    // round-robin pointer is the last (winning) assignment.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_q} + 4'(k);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (idx == 4'(i) && REQ[i]) begin
                    sel = 3'(i);
                end
            end
        end
    end

    always_comb begin
        sel_val  = '0;
        cncl_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == 3'(i)) begin
                sel_val = REQ_VALUE[i*CW +: CW];
            end
            if (cur_id_q == 3'(i) && CANCEL[i]) begin
                cncl_hit = 1'b1;
            end
        end
    end

    assign rr_next = (cur_id_q == 3'(NREQ - 1)) ? 3'd0 : cur_id_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        done_d    = '0;
        cncl_d    = '0;
        busy_d    = busy_q;
        cur_id_d  = cur_id_q;
        rr_d      = rr_q;
        time_d    = time_q;
        tmr_rst_d = tmr_rst_q;
        tmr_msk_d = tmr_msk_q;
        val_d     = val_q;
        unique case (state_q)
            S_IDLE: begin
                tmr_rst_d = 1'b1;
                tmr_msk_d = 1'b0;
                busy_d    = 1'b0;
                if (|REQ) begin
                    state_d  = S_LOAD;
                    busy_d   = 1'b1;
                    cur_id_d = sel;
                    val_d    = sel_val;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (sel == 3'(i));
                    end
                end
            end
            // Timer stays in reset for this cycle with the new
            // compare value already present.
            S_LOAD: begin
                state_d   = S_RUN;
                tmr_rst_d = 1'b0;
                tmr_msk_d = 1'b1;
            end
            S_RUN: begin
                if (TMR_INT || cncl_hit) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    tmr_rst_d = 1'b1;
                    tmr_msk_d = 1'b0;
                    rr_d      = rr_next;
                    // Completion beats a same-cycle cancel.
                    for (int i = 0; i < NREQ; i++) begin
                        done_d[i] = TMR_INT && (cur_id_q == 3'(i));
                        cncl_d[i] = !TMR_INT && (cur_id_q == 3'(i));
                    end
                    if (TMR_INT) begin
                        time_d = time_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RSTTPU_N) begin
        if (!RSTTPU_N) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            cncl_q    <= '0;
            busy_q    <= 1'b0;
            cur_id_q  <= '0;
            rr_q      <= '0;
            time_q    <= '0;
            tmr_rst_q <= 1'b1;
            tmr_msk_q <= 1'b0;
            val_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cncl_q    <= cncl_d;
            busy_q    <= busy_d;
            cur_id_q  <= cur_id_d;
            rr_q      <= rr_d;
            time_q    <= time_d;
            tmr_rst_q <= tmr_rst_d;
            tmr_msk_q <= tmr_msk_d;
            val_q     <= val_d;
        end
    end

    assign GNT           = gnt_q;
    assign DONE          = done_q;
    assign CNCL_ACK      = cncl_q;
    assign BUSY          = busy_q;
    assign CUR_ID        = cur_id_q;
    assign TIME          = time_q;
    assign TMR_RST       = tmr_rst_q;
    assign TMR_INTMSK    = tmr_msk_q;
    assign TMR_INT_VALUE = val_q;

endmodule

// File: tb/tb_tpu_timer_sched.sv
// tb_tpu_timer_sched: randomized jobs against a transaction-level model;
// expected pulses and per-cycle status go to a scoreboard and monitor.
module tb_tpu_timer_sched;

    localparam int NREQ = 4;
    localparam int CW   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ*CW-1:0] req_value = '0;
    logic [NREQ-1:0]  cancel = '0;
    logic             tmr_int = 1'b0;
    logic [NREQ-1:0]  gnt, done, cncl_ack;
    logic             busy;
    logic [2:0]       cur_id;
    logic [7:0]       time_cnt;
    logic             tmr_rst, tmr_msk;
    logic [CW-1:0]    tmr_val;

    tpu_timer_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .SYS_CLK(clk),
        .RSTTPU_N(rst_n),
        .REQ(req),
        .REQ_VALUE(req_value),
        .CANCEL(cancel),
        .GNT(gnt),
        .DONE(done),
        .CNCL_ACK(cncl_ack),
        .BUSY(busy),
        .CUR_ID(cur_id),
        .TIME(time_cnt),
        .TMR_RST(tmr_rst),
        .TMR_INTMSK(tmr_msk),
        .TMR_INT_VALUE(tmr_val),
        .TMR_INT(tmr_int)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // kind: 0 grant, 1 done, 2 cancel-ack
    typedef struct {
        int kind;
        int id;
        int c;
    } ev_t;

    ev_t         sbq[$];
    logic [29:0] exp_lvl[int];
    int          checks = 0;
    int          failures = 0;

    // Reference model state
    int              m_rr = 0;
    int              m_id = 0;
    logic [CW-1:0]   m_val = '0;
    logic [7:0]      m_time = '0;
    logic [NREQ-1:0] pending = '0;
    logic [CW-1:0]   vals[NREQ];
    int              n_done = 0;
    int              dir_val = -1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [29:0] lvl(input bit b, input bit r, input bit m);
        return {b, r, m, 3'(m_id), m_val, m_time};
    endfunction

    function automatic int arb();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (pending[i]) return i;
        end
        return -1;
    endfunction

    task automatic push_ev(input int kind, input int id, input int c);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.c    = c;
        sbq.push_back(e);
    endtask

    task automatic rand_vals();
        for (int i = 0; i < NREQ; i++) begin
            if (dir_val >= 0) vals[i] = CW'(dir_val);
            else if ($urandom_range(0, 7) == 0) vals[i] = '0;
            else vals[i] = CW'($urandom);
            req_value[i*CW +: CW] = vals[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle status and pulse scoreboard
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] pv;
        int kind;
        ev_t e;
        if (rst_n) begin
            while (sbq.size() > 0 && sbq[0].c < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_pulse kind=%0d id=%0d due %0d now %0d",
                         sbq[0].kind, sbq[0].id, sbq[0].c, cyc);
                void'(sbq.pop_front());
            end
            if (exp_lvl.exists(cyc)) begin
                chk("levels", {busy, tmr_rst, tmr_msk, cur_id, tmr_val, time_cnt},
                    exp_lvl[cyc]);
                exp_lvl.delete(cyc);
            end
            chk("pulse_onehot", 64'($countones({gnt, done, cncl_ack}) <= 1), 1);
            pv = gnt | done | cncl_ack;
            kind = (|gnt) ? 0 : (|done) ? 1 : (|cncl_ack) ? 2 : -1;
            if (kind >= 0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse kind=%0d vec=%b cycle %0d",
                             kind, pv, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_kind", 64'(kind), 64'(e.kind));
                    chk("pulse_vec", 64'(pv), 64'(4'b0001 << e.id));
                    chk("pulse_cycle", 64'(cyc), 64'(e.c));
                end
            end
        end
    end

    // Called one ns after an edge that left the DUT in IDLE.
    // outcome: 0 timer done, 1 cancel, 2 both on the same edge.
    task automatic episode(input logic [NREQ-1:0] add, input int L,
                           input int outcome, input bit keep);
        int w, g, e;
        pending = pending | add;
        rand_vals();
        req = pending;
        tmr_int = 1'($urandom_range(0, 1));
        cancel = NREQ'($urandom);
        w = arb();
        g = cyc + 1;
        e = g + 1 + L;
        step();
        push_ev(0, w, g);
        m_id = w;
        m_val = vals[w];
        exp_lvl[g] = lvl(1, 1, 0);
        if (!keep) pending[w] = 1'b0;
        rand_vals();
        req = pending;
        tmr_int = 1'($urandom_range(0, 1));
        cancel = NREQ'($urandom);
        for (int c = g + 1; c < e; c++) begin
            step();
            exp_lvl[c] = lvl(1, 0, 1);
            rand_vals();
            tmr_int = (c == e - 1) && (outcome != 1);
            cancel = NREQ'($urandom) & ~(NREQ'(1) << w);
            if (c == e - 1 && outcome != 0) cancel[w] = 1'b1;
        end
        step();
        if (outcome == 1) begin
            push_ev(2, w, e);
        end else begin
            m_time = m_time + 8'd1;
            n_done++;
            push_ev(1, w, e);
        end
        m_rr = (w + 1) % NREQ;
        exp_lvl[e] = lvl(0, 1, 0);
        tmr_int = 1'b0;
        cancel = '0;
    endtask

    // Idle cycles with no requests; interrupt and cancel noise is ignored.
    task automatic gap(input int n, input bit force_int);
        for (int k = 0; k < n; k++) begin
            req = '0;
            tmr_int = force_int ? 1'b1 : 1'($urandom_range(0, 1));
            cancel = NREQ'($urandom);
            rand_vals();
            step();
            exp_lvl[cyc] = lvl(0, 1, 0);
        end
        tmr_int = 1'b0;
        cancel = '0;
    endtask

    initial begin
        int guard;
        int w;
        int g;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_tmr_rst", 64'(tmr_rst), 1);
        chk("rst_intmsk", 64'(tmr_msk), 0);
        chk("rst_pulses", 64'({gnt, done, cncl_ack}), 0);
        chk("rst_time", 64'(time_cnt), 0);
        chk("rst_cur_id", 64'(cur_id), 0);
        chk("rst_value", 64'(tmr_val), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        exp_lvl[cyc] = lvl(0, 1, 0);

        // single job, value 5
        dir_val = 5;
        episode(4'b0001, 7, 0, 0);
        dir_val = -1;

        // round robin with all requesters holding REQ
        for (int j = 0; j < 5; j++) episode(4'b1111, 3, 0, 1);
        while (pending != '0) episode('0, $urandom_range(1, 4), 0, 0);

        // cancel on owner, then collision, then interrupt in IDLE
        episode(4'b0100, 2, 1, 0);
        episode(4'b0010, 2, 2, 0);
        gap(3, 1'b1);

        guard = 0;
        while (n_done < 300 && guard < 3000) begin
            int oc;
            guard++;
            oc = ($urandom_range(0, 3) == 0) ? 1 :
                 ($urandom_range(0, 5) == 0) ? 2 : 0;
            if (pending == '0) begin
                gap($urandom_range(0, 2), 1'b0);
                episode(NREQ'($urandom_range(1, 15)), $urandom_range(1, 6), oc,
                        1'($urandom_range(0, 1)));
            end else begin
                episode(NREQ'($urandom) & NREQ'($urandom),
                        $urandom_range(1, 6), oc, 1'($urandom_range(0, 1)));
            end
        end
        chk("enough_done", 64'(n_done >= 300), 1);

        // reset in the middle of a job
        pending = pending | 4'b1111;
        rand_vals();
        req = pending;
        w = arb();
        g = cyc + 1;
        step();
        push_ev(0, w, g);
        m_id = w;
        m_val = vals[w];
        exp_lvl[g] = lvl(1, 1, 0);
        tmr_int = 1'b0;
        cancel = '0;
        step();
        exp_lvl[cyc] = lvl(1, 0, 1);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_tmr_rst", 64'(tmr_rst), 1);
        chk("mid_rst_intmsk", 64'(tmr_msk), 0);
        chk("mid_rst_pulses", 64'({gnt, done, cncl_ack}), 0);
        chk("mid_rst_time", 64'(time_cnt), 0);
        exp_lvl.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        m_rr = 0;
        m_time = '0;
        m_id = 0;
        m_val = '0;
        exp_lvl[cyc] = lvl(0, 1, 0);
        episode('0, 2, 0, 0);
        while (pending != '0) episode('0, $urandom_range(1, 3), 0, 0);
        gap(3, 1'b0);
        chk("scoreboard_empty", 64'(sbq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
